// File: rtl/pipe_pkg.sv
// Shared types and defaults for the IF/ID pipeline skid register.
package pipe_pkg;

  localparam int unsigned IFID_DATA_W = 96;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } pipe_state_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached. Cleared by RST only.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between pipeline stages; all outputs come straight from flops.
// Optional back-pressure statistics under `PIPE_SKID_STATS_EN (adds stall_cnt port).
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = IFID_DATA_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, out_valid_q;
  logic              accept, take;

  assign accept = in_valid && in_ready_q;
  assign take   = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Redirect wins over any handshake; offered data is dropped.
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && take) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (take) begin
            main_d  = '0;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (take) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      // Handshake flags are registered copies of the next-state decode.
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

`ifdef PIPE_SKID_STATS_EN
  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (out_valid_q && !out_ready),
    .count(stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized bench for pipe_skid_reg against a two-slot FIFO reference model.
module tb_pipe_skid_reg;

  localparam int unsigned DATA_W = 96;
  localparam int unsigned CNT_W  = 3;

  logic              CLK;
  logic              RST;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_SKID_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  pipe_skid_reg #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned       n_vec = 0;
  int unsigned       n_err = 0;
  logic [DATA_W-1:0] mq[$];
  int unsigned       mcnt = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [DATA_W-1:0] exp_data;
    exp_data = (mq.size() > 0) ? mq[0] : '0;
    check("out_valid", {127'd0, out_valid}, {127'd0, mq.size() > 0});
    check("in_ready", {127'd0, in_ready}, {127'd0, mq.size() < 2});
    check("out_data", {32'd0, out_data}, {32'd0, exp_data});
`ifdef PIPE_SKID_STATS_EN
    check("stall_cnt", {125'd0, stall_cnt}, 128'(mcnt));
`endif
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then compare.
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [DATA_W-1:0] d, input logic ordy);
    int unsigned sz;
    RST       = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge CLK);
    sz = mq.size();
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (sz > 0 && !ordy && mcnt < (1 << CNT_W) - 1) mcnt++;
      if (fl) begin
        mq.delete();
      end else begin
        if (sz > 0 && ordy) void'(mq.pop_front());
        if (iv && sz < 2) mq.push_back(d);
      end
    end
    #1;
    check_all();
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset then stream 1,2,3.
    cycle(1, 0, 0, '0, 0);
    cycle(1, 0, 0, '0, 0);
    check("rst_out_data", {32'd0, out_data}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    cycle(0, 0, 1, 96'd1, 1);
    check("stream_1", {32'd0, out_data}, 128'd1);
    cycle(0, 0, 1, 96'd2, 1);
    check("stream_2", {32'd0, out_data}, 128'd2);
    cycle(0, 0, 1, 96'd3, 1);
    check("stream_3", {32'd0, out_data}, 128'd3);
    check("stream_rdy", {127'd0, in_ready}, 128'd1);
    cycle(0, 0, 0, '0, 1);

    // Back-pressure: A, B held, C held off, then drain.
    cycle(0, 0, 1, 96'hA, 0);
    cycle(0, 0, 1, 96'hB, 0);
    check("bp_full", {127'd0, in_ready}, 128'd0);
    cycle(0, 0, 1, 96'hC, 0);
    check("bp_hold", {32'd0, out_data}, 128'hA);
    cycle(0, 0, 1, 96'hC, 1);
    check("bp_b", {32'd0, out_data}, 128'hB);
    cycle(0, 0, 1, 96'hC, 1);
    check("bp_c", {32'd0, out_data}, 128'hC);
    cycle(0, 0, 0, '0, 1);

    // Flush while FULL with D offered.
    cycle(0, 0, 1, 96'hA, 0);
    cycle(0, 0, 1, 96'hB, 0);
    cycle(0, 1, 1, 96'hD, 0);
    check("flush_valid", {127'd0, out_valid}, 128'd0);
    cycle(0, 0, 0, '0, 1);

    // Accept and take together in ONE.
    cycle(0, 0, 1, 96'hA, 0);
    cycle(0, 0, 1, 96'h5A5A, 1);
    check("simul_x", {32'd0, out_data}, 128'h5A5A);
    check("simul_rdy", {127'd0, in_ready}, 128'd1);
    cycle(0, 0, 0, '0, 1);

    // Reset while FULL with flush.
    cycle(0, 0, 1, 96'h11, 0);
    cycle(0, 0, 1, 96'h22, 0);
    cycle(1, 1, 1, 96'h33, 0);
    check("midrst_valid", {127'd0, out_valid}, 128'd0);

`ifdef PIPE_SKID_STATS_EN
    // Saturate the stall counter, then flush must not clear it.
    cycle(0, 0, 1, 96'h77, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, '0, 0);
    check("stats_sat", {125'd0, stall_cnt}, 128'd7);
    cycle(0, 1, 0, '0, 0);
    cycle(0, 0, 0, '0, 0);
    check("stats_flush", {125'd0, stall_cnt}, 128'd7);
`endif

    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 5,
            $urandom_range(0, 9) < 7, rnd_data(), $urandom_range(0, 9) < 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 96, meaning the payload width (instr + PC + PC+4).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the stall-counter width (used only under PIPE_SKID_STATS_EN).
REQ-003 CLK  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 flush  in  1  discards all held entries (branch/jump redirect).
REQ-006 in_valid  in  1  the upstream stage offers in_data.
REQ-007 in_ready  out  1  the block can accept data; driven from a register only.
REQ-008 in_data  in  DATA_W  upstream payload.
REQ-009 out_valid  out  1  out_data holds a valid entry.
REQ-010 out_ready  in  1  the downstream stage takes out_data this cycle.
REQ-011 out_data  out  DATA_W  downstream payload; driven from a register only.
REQ-012 stall_cnt  out  CNT_W  count of back-pressure cycles; present only under PIPE_SKID_STATS_EN.

Function
REQ-013 Accept SHALL mean in_valid && in_ready; take SHALL mean out_valid && out_ready; both are sampled at the rising edge of CLK.
REQ-014 The block SHALL hold two entries: a main register driving out_data and a skid register.
REQ-015 The state machine SHALL have three states: EMPTY, ONE and FULL.
REQ-016 out_valid SHALL be 1 when the state is not EMPTY; in_ready SHALL be 1 when the state is not FULL.
REQ-017 In EMPTY, an accept SHALL load main and move to ONE.
REQ-018 In ONE, accept and take together SHALL load main with in_data and stay in ONE.
REQ-019 In ONE, accept without take SHALL load skid and move to FULL; main SHALL hold.
REQ-020 In ONE, take without accept SHALL move to EMPTY and clear main to 0.
REQ-021 In FULL, a take SHALL copy skid into main, clear skid and move to ONE; no accept is possible in FULL.
REQ-022 Latency from accept to out_valid SHALL be exactly 1 cycle; with out_ready held at 1, throughput SHALL be 1 entry per cycle.
REQ-023 Entries SHALL leave in the order they were accepted; none SHALL be lost or duplicated.
REQ-024 flush SHALL move the block to EMPTY and clear main and skid to 0 on the next edge.
REQ-025 flush SHALL take priority over any accept or take in the same cycle; data offered on that cycle is dropped.
REQ-026 While EMPTY, out_data SHALL be 0, a bubble that decodes as a null instruction.
REQ-027 out_data SHALL stay stable while out_valid && !out_ready.

Reset
REQ-028 While RST is 1, the state SHALL be EMPTY, main and skid SHALL be 0, and therefore out_valid=0, out_data=0 and in_ready=1 from the edge after RST rises.
REQ-029 RST SHALL take priority over flush and over any handshake, including mid-transfer.
REQ-030 stall_cnt SHALL be cleared to 0 by RST only; flush SHALL NOT clear it.

Configuration
REQ-031 With macro PIPE_SKID_STATS_EN defined, stall_cnt SHALL exist and increment on each cycle with out_valid && !out_ready, saturating at 2^CNT_W-1.
REQ-032 Without PIPE_SKID_STATS_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 Shared package pipe_pkg SHALL hold the state enum pipe_state_t (ST_EMPTY, ST_ONE, ST_FULL) and the localparam default IFID_DATA_W=96.
REQ-034 The saturating counter SHALL be the sub-module pipe_sat_counter (parameter CNT_W; ports CLK, RST, inc, count), instantiated only under PIPE_SKID_STATS_EN.

Verification
REQ-035 Reset then stream: RST=1 for 2 cycles, then in_valid=1 with data 1,2,3 and out_ready=1 -> out_valid rises 1 cycle after the first accept; out_data=1,2,3 on consecutive cycles; in_ready stays 1.
REQ-036 Back-pressure: out_ready=0 and offer A then B -> after B, in_ready=0; C is held off; after out_ready=1, out_data=A then B then C; nothing lost or duplicated.
REQ-037 Flush in FULL: hold A,B, then assert flush with in_valid=1 carrying D -> next cycle out_valid=0, out_data=0 and in_ready=1; D never appears.
REQ-038 Simultaneous events in ONE: accept X and take together -> out_data=X next cycle and the state stays ONE (in_ready=1).
REQ-039 Reset mid-operation: RST asserted while FULL with flush=1 -> all outputs return to their reset values next edge; stall_cnt=0.
REQ-040 Stats (macro on, CNT_W=3): hold out_valid=1 and out_ready=0 for 10 cycles -> stall_cnt saturates at 7; a later flush leaves stall_cnt at 7.
